// File: rtl/decode_seq.sv
// Elastic fetch->decode buffer that classifies each opcode into an immediate format.
// Define DECODE_SEQ_PERF_EN to add saturating stall/full performance counters.
module decode_seq #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
`ifdef DECODE_SEQ_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             fetch_valid,
    output logic             fetch_retry,
    input  logic [31:0]      fetch_insn,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             decode_valid,
    input  logic             decode_retry,
    output logic [31:0]      decode_insn,
    output logic [XLEN-1:0]  decode_pc,
    output logic [2:0]       decode_fmt,
    output logic             decode_illegal
`ifdef DECODE_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_full_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    logic [31:0]     insn_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [2:0]      fmt_q  [DEPTH];

    function automatic logic [2:0] classify(input logic [31:0] insn);
        logic [6:0] op;
        logic [2:0] f;
        op = insn[6:0];
        unique case (1'b1)
            op == 7'b0010011, op == 7'b0000011, op == 7'b1100111,
            op == 7'b0011011, op == 7'b1110011: f = 3'd0;
            op == 7'b0100011:                   f = 3'd1;
            op == 7'b1100011:                   f = 3'd2;
            op == 7'b0110111, op == 7'b0010111: f = 3'd3;
            op == 7'b1101111:                   f = 3'd4;
            op == 7'b0110011, op == 7'b0111011: f = 3'd5;
            default:                            f = 3'd7;
        endcase
        if (insn[1:0] != 2'b11) f = 3'd7;
        return f;
    endfunction

    // Retry comes from registered state only, so a full buffer never passes through.
    assign fetch_retry  = (state == FULL);
    assign decode_valid = (cnt != '0) && !flush;
    assign push         = fetch_valid && !fetch_retry && !flush;
    assign pop          = decode_valid && !decode_retry;

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)
            cnt_nxt = cnt + CW'(1);
        else if (pop && !push)
            cnt_nxt = cnt - CW'(1);
    end

    assign decode_insn    = insn_q[rd_ptr];
    assign decode_pc      = pc_q[rd_ptr];
    assign decode_fmt     = decode_valid ? fmt_q[rd_ptr] : 3'd7;
    assign decode_illegal = decode_valid && (fmt_q[rd_ptr] == 3'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (cnt_nxt == '0)
                state <= EMPTY;
            else if (cnt_nxt == CW'(DEPTH))
                state <= FULL;
            else
                state <= PARTIAL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                insn_q[i] <= '0;
                pc_q[i]   <= '0;
                fmt_q[i]  <= 3'd7;
            end
        end else if (push) begin
            insn_q[wr_ptr] <= fetch_insn;
            pc_q[wr_ptr]   <= fetch_pc;
            fmt_q[wr_ptr]  <= classify(fetch_insn);
        end
    end

`ifdef DECODE_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_full_cnt  <= '0;
        end else begin
            if (decode_valid && decode_retry && !(&perf_stall_cnt))
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            if (fetch_valid && fetch_retry && !(&perf_full_cnt))
                perf_full_cnt <= perf_full_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_decode_seq.sv
// Randomised and directed bench for decode_seq against a queue-based reference model.
module tb_decode_seq;

    localparam int DEPTH = 2;
    localparam int XLEN  = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            fetch_valid;
    logic            fetch_retry;
    logic [31:0]     fetch_insn;
    logic [XLEN-1:0] fetch_pc;
    logic            decode_valid;
    logic            decode_retry;
    logic [31:0]     decode_insn;
    logic [XLEN-1:0] decode_pc;
    logic [2:0]      decode_fmt;
    logic            decode_illegal;
`ifdef DECODE_SEQ_PERF_EN
    logic [15:0]     perf_stall_cnt;
    logic [15:0]     perf_full_cnt;
`endif

    always #5 clk = ~clk;

    decode_seq #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .fetch_valid(fetch_valid),
        .fetch_retry(fetch_retry),
        .fetch_insn(fetch_insn),
        .fetch_pc(fetch_pc),
        .decode_valid(decode_valid),
        .decode_retry(decode_retry),
        .decode_insn(decode_insn),
        .decode_pc(decode_pc),
        .decode_fmt(decode_fmt),
        .decode_illegal(decode_illegal)
`ifdef DECODE_SEQ_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_full_cnt(perf_full_cnt)
`endif
    );

    typedef struct {
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
        logic [2:0]      fmt;
    } entry_t;

    entry_t q[$];
    int     checks = 0;
    int     errors = 0;
    int     m_stall = 0;
    int     m_full = 0;
    int     max_fill = 0;
    bit     last_acc;

    localparam logic [6:0] OPS [12] = '{
        7'h13, 7'h03, 7'h67, 7'h1B, 7'h73, 7'h23,
        7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
    localparam logic [2:0] FMTS [12] = '{
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1,
        3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd5};

    function automatic logic [2:0] ref_fmt(input logic [31:0] i);
        for (int k = 0; k < 12; k++)
            if (i[6:0] == OPS[k]) return FMTS[k];
        return 3'd7;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit mv;
        mv = (q.size() != 0) && !flush;
        chk("decode_valid", 64'(decode_valid), 64'(mv));
        chk("fetch_retry", 64'(fetch_retry), 64'(q.size() == DEPTH));
        if (mv) begin
            chk("decode_insn", 64'(decode_insn), 64'(q[0].insn));
            chk("decode_pc", decode_pc, q[0].pc);
            chk("decode_fmt", 64'(decode_fmt), 64'(q[0].fmt));
            chk("decode_illegal", 64'(decode_illegal), 64'(q[0].fmt == 3'd7));
        end else begin
            chk("idle_fmt", 64'(decode_fmt), 64'd7);
            chk("idle_illegal", 64'(decode_illegal), 64'd0);
        end
`ifdef DECODE_SEQ_PERF_EN
        chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
        chk("perf_full", 64'(perf_full_cnt), 64'(m_full));
`endif
    endtask

    // One clock cycle: drive, check, then advance the model across the edge.
    task automatic step(input bit fv, input logic [31:0] insn,
                        input logic [63:0] pc, input bit dr, input bit fl);
        bit mv, mr, acc, pop;
        fetch_valid  = fv;
        fetch_insn   = insn;
        fetch_pc     = pc;
        decode_retry = dr;
        flush        = fl;
        #1;
        check_outputs();
        mv  = (q.size() != 0) && !fl;
        mr  = (q.size() == DEPTH);
        acc = fv && !mr && !fl;
        pop = mv && !dr;
        @(posedge clk);
        if (mv && dr && m_stall < 16'hFFFF) m_stall++;
        if (fv && mr && m_full < 16'hFFFF) m_full++;
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{insn, pc, ref_fmt(insn)});
        end
        last_acc = acc;
        if (q.size() > max_fill) max_fill = q.size();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit dr);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 64'h0, dr, 1'b0);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) < 8)
            r[6:0] = OPS[$urandom_range(0, 11)];
        return r;
    endfunction

    initial begin
        logic [31:0] ri;
        logic [63:0] rp;
        bit          rv;
        reset = 1'b0;
        flush = 1'b0;
        fetch_valid = 1'b0;
        fetch_insn = '0;
        fetch_pc = '0;
        decode_retry = 1'b0;

        // Reset held low
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 64'(decode_valid), 64'd0);
        chk("rst_retry", 64'(fetch_retry), 64'd0);
        chk("rst_fmt", 64'(decode_fmt), 64'd7);
        chk("rst_insn", 64'(decode_insn), 64'd0);
        chk("rst_pc", decode_pc, 64'd0);
        chk("rst_illegal", 64'(decode_illegal), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(5, 1'b0);

        // Stream: addi, beq, jal
        step(1'b1, 32'h00500093, 64'h1000, 1'b0, 1'b0);
        step(1'b1, 32'hFE0008E3, 64'h1004, 1'b0, 1'b0);
        step(1'b1, 32'h008000EF, 64'h1008, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Backpressure: three beats into a two-entry buffer
        step(1'b1, 32'h00000013, 64'h2000, 1'b1, 1'b0);
        step(1'b1, 32'h00112023, 64'h2004, 1'b1, 1'b0);
        step(1'b1, 32'h12345037, 64'h2008, 1'b1, 1'b0);
        step(1'b1, 32'h12345037, 64'h2008, 1'b1, 1'b0);
        step(1'b1, 32'h12345037, 64'h2008, 1'b0, 1'b0);
        while (!last_acc)
            step(1'b1, 32'h12345037, 64'h2008, 1'b0, 1'b0);
        idle(4, 1'b0);

        // Wrap: ten beats with alternating consumer stall
        for (int i = 0; i < 10; i++) begin
            ri = 32'h00A00033 | (32'(i) << 20);
            step(1'b1, ri, 64'h3000 + 64'(4 * i), i[0], 1'b0);
            while (!last_acc)
                step(1'b1, ri, 64'h3000 + 64'(4 * i), 1'b0, 1'b0);
        end
        idle(4, 1'b0);
        chk("max_fill", 64'(max_fill), 64'(DEPTH));

        // Flush with a concurrent fetch beat
        step(1'b1, 32'h00000017, 64'h4000, 1'b1, 1'b0);
        step(1'b1, 32'h0000006F, 64'h4004, 1'b1, 1'b0);
        step(1'b1, 32'hDEADB0B3, 64'h4008, 1'b0, 1'b1);
        idle(3, 1'b0);

        // Illegal opcode held under stall
        step(1'b1, 32'h00000000, 64'h5000, 1'b1, 1'b0);
        idle(4, 1'b1);
        idle(2, 1'b0);
        step(1'b1, 32'h0000007F, 64'h5004, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Asynchronous reset mid-operation
        step(1'b1, 32'h00000063, 64'h6000, 1'b1, 1'b0);
        step(1'b1, 32'h00000003, 64'h6004, 1'b1, 1'b0);
        fetch_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 64'(decode_valid), 64'd0);
        chk("arst_retry", 64'(fetch_retry), 64'd0);
        chk("arst_fmt", 64'(decode_fmt), 64'd7);
        q.delete();
        m_stall = 0;
        m_full = 0;
        @(negedge clk);
        reset = 1'b1;
        idle(2, 1'b0);

        // Random traffic
        rv = 1'b0;
        ri = '0;
        rp = 64'h8000;
        for (int n = 0; n < 400; n++) begin
            if (!rv || last_acc) begin
                rv = ($urandom_range(0, 9) < 7);
                ri = rand_insn();
                rp = rp + 64'd4;
            end
            step(rv, ri, rp, ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 29) == 0));
        end
        idle(4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
